// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC fetcher and executor.
//   fetch_state_e : fetcher FSM state encoding (3 bits)
//   END_OP        : opcode that terminates a scan early; it is still issued
//   REG_A..OTHER  : executor opcode classes (instr[7:6]) so both blocks agree
package vslc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SCAN_START = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_GAP        = 3'd4,
    ST_SCAN_END   = 3'd5
  } fetch_state_e;

  localparam logic [7:0] END_OP = 8'hFF;

  localparam logic [1:0] REG_A = 2'b00;
  localparam logic [1:0] REG_B = 2'b01;
  localparam logic [1:0] LOGIC = 2'b10;
  localparam logic [1:0] OTHER = 2'b11;

endpackage

// File: rtl/tt_um_jimktrains_vslc_fetcher_if.sv
// Bus between the host/executor side and the VSLC fetcher.
//   master : drives run, prog_en, prog_bit, prog_strobe, ui_in; observes fetcher outputs
//   slave  : the fetcher; drives instr, instr_ready, ui_in_prev, scan_done, busy,
//            prog_len, overflow
interface tt_um_jimktrains_vslc_fetcher_if #(
  parameter int ADDR_W = 4
);
  logic            run;
  logic            prog_en;
  logic            prog_bit;
  logic            prog_strobe;
  logic [7:0]      ui_in;
  logic [7:0]      instr;
  logic            instr_ready;
  logic [7:0]      ui_in_prev;
  logic            scan_done;
  logic            busy;
  logic [ADDR_W:0] prog_len;
  logic            overflow;

  modport master (
    output run, prog_en, prog_bit, prog_strobe, ui_in,
    input  instr, instr_ready, ui_in_prev, scan_done, busy, prog_len, overflow
  );

  modport slave (
    input  run, prog_en, prog_bit, prog_strobe, ui_in,
    output instr, instr_ready, ui_in_prev, scan_done, busy, prog_len, overflow
  );
endinterface

// File: rtl/tt_um_jimktrains_vslc_prog_shift.sv
// Serial program receiver: detects rising edges of the host bit clock, shifts
// bits in MSB first and flags each completed byte.
//   clk, rst    : system clock, async active-high reset
//   clear       : drop any partial byte (asserted on LOAD entry)
//   enable      : accept bits (only while loading)
//   strobe      : host bit clock, synchronous to clk
//   bit_in      : serial data
//   byte_valid  : one-cycle flag, byte_data complete this cycle
//   byte_data   : assembled byte (last bit taken straight from bit_in)
module tt_um_jimktrains_vslc_prog_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       strobe,
  input  logic       bit_in,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  // The edge detector runs regardless of enable so that a strobe already
  // high when loading starts is not mistaken for a new edge.
  logic       strobe_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rise;

  always_comb begin
    rise       = strobe & ~strobe_prev_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_data  = {shift_q, bit_in};
    if (clear) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (enable && rise) begin
      shift_d    = {shift_q[5:0], bit_in};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_valid = (bit_cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_prev_q <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
    end else begin
      strobe_prev_q <= strobe;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
    end
  end

endmodule

// File: rtl/tt_um_jimktrains_vslc_fetcher.sv
// VSLC instruction fetcher: loads a program serially into a small RAM, then
// replays it as a scan loop, one instr_ready strobe per instruction, and
// provides the previous scan's input snapshot for edge detection.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of tt_um_jimktrains_vslc_fetcher_if
//
// state         | meaning
// ST_IDLE       | waiting for run (needs a non-empty program) or prog_en
// ST_LOAD       | receiving serial program bytes
// ST_SCAN_START | snapshot ui_in, rotate previous snapshot, pc <= 0
// ST_ISSUE      | instr_ready high for one cycle with mem[pc]
// ST_GAP        | idle spacing between instructions
// ST_SCAN_END   | scan_done pulse; loop again if run is still high
module tt_um_jimktrains_vslc_fetcher
  import vslc_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int GAP_CYCLES = 1
) (
  input logic                           clk,
  input logic                           rst,
  tt_um_jimktrains_vslc_fetcher_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);
  // Gap timer counts down to zero; loaded with GAP_CYCLES-1 on entry.
  localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        instr_q, instr_d;
  logic              instr_ready_q, instr_ready_d;
  logic [7:0]        ui_prev_q, ui_prev_d;
  logic [7:0]        ui_cur_q, ui_cur_d;
  logic [3:0]        gap_q, gap_d;
  logic              load_entry;
  logic              mem_we;
  logic              sh_valid;
  logic [7:0]        sh_data;

  tt_um_jimktrains_vslc_prog_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_entry),
    .enable     ((state_q == ST_LOAD) && bus.prog_en),
    .strobe     (bus.prog_strobe),
    .bit_in     (bus.prog_bit),
    .byte_valid (sh_valid),
    .byte_data  (sh_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    instr_d    = instr_q;
    ui_prev_d  = ui_prev_q;
    ui_cur_d   = ui_cur_q;
    gap_d      = gap_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run && (prog_len_q != '0)) state_d = ST_SCAN_START;
      end
      ST_LOAD: begin
        if (!bus.prog_en) state_d = ST_IDLE;
        if (sh_valid) begin
          if (prog_len_q == FULL_LEN) begin
            overflow_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + 1'b1;
          end
        end
      end
      ST_SCAN_START: begin
        ui_prev_d = ui_cur_q;
        ui_cur_d  = bus.ui_in;
        pc_d      = '0;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if ((mem[pc_q] == END_OP) || ({1'b0, pc_q} == prog_len_q - 1'b1)) begin
          state_d = ST_SCAN_END;
        end else begin
          pc_d = pc_q + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_ISSUE;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_SCAN_END: begin
        state_d = bus.run ? ST_SCAN_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Program load wins over everything, including a scan in flight.
    if (bus.prog_en && (state_q != ST_LOAD)) state_d = ST_LOAD;

    load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    if (load_entry) begin
      prog_len_d = '0;
      overflow_d = 1'b0;
    end

    // instr and instr_ready are registered together so instr is valid for
    // exactly the cycle the strobe is high, then held through the gap.
    instr_ready_d = (state_d == ST_ISSUE);
    if (instr_ready_d) instr_d = mem[pc_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      instr_q       <= '0;
      instr_ready_q <= 1'b0;
      ui_prev_q     <= '0;
      ui_cur_q      <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      prog_len_q    <= prog_len_d;
      overflow_q    <= overflow_d;
      instr_q       <= instr_d;
      instr_ready_q <= instr_ready_d;
      ui_prev_q     <= ui_prev_d;
      ui_cur_q      <= ui_cur_d;
      gap_q         <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_len_q[ADDR_W-1:0]] <= sh_data;
  end

  assign bus.instr       = instr_q;
  assign bus.instr_ready = instr_ready_q;
  assign bus.ui_in_prev  = ui_prev_q;
  assign bus.scan_done   = (state_q == ST_SCAN_END);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.prog_len    = prog_len_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/tt_um_jimktrains_vslc_fetcher.md
Name: tt_um_jimktrains_vslc_fetcher

Overview:
Instruction source for the VSLC executor. Accepts a bit-serial program download into a small internal program RAM. It then replays the program as a continuous scan loop, driving instr and a one-cycle instr_ready strobe per instruction. It also supplies the per-scan input snapshot that the executor uses as ui_in_prev for edge detection.

Parameters:
DEPTH, 16, number of program bytes held in RAM (power of two, 2..256)
ADDR_W, $clog2(DEPTH), RAM address width
GAP_CYCLES, 1, idle cycles with instr_ready low between consecutive instructions (0..15)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
run  input  1  level; request scan execution
prog_en  input  1  level; program-load mode, overrides run
prog_bit  input  1  serial program data, MSB first
prog_strobe  input  1  bit clock from host, synchronous to clk, rising edge detected internally
ui_in  input  8  live inputs, snapshotted per scan
instr  output  8  current instruction to executor
instr_ready  output  1  one-cycle strobe, instr valid
ui_in_prev  output  8  inputs captured at start of previous scan
scan_done  output  1  one-cycle pulse at end of each scan
busy  output  1  high in any state except IDLE
prog_len  output  ADDR_W+1  bytes loaded
overflow  output  1  sticky: byte received with RAM full

Behaviour:
- Reset (async, rst=1): state=IDLE; instr=0, instr_ready=0, ui_in_prev=0, internal ui_cur=0, scan_done=0, busy=0, prog_len=0, overflow=0, pc=0, bit count=0. RAM contents are not reset.
- States: IDLE, LOAD, SCAN_START, ISSUE, GAP, SCAN_END.
- Priority: prog_en high beats run in every state. From any non-LOAD state, prog_en=1 moves to LOAD on the next edge, and instr_ready is 0 from that edge on. An in-progress scan is aborted with no scan_done.
- Entering LOAD clears prog_len, bit count and overflow.
- LOAD:
  - Each prog_strobe rising edge (prev=0, cur=1 sampled on clk) shifts prog_bit into the shift register.
  - On the 8th bit, the byte is written to mem[prog_len] and prog_len increments.
  - If prog_len==DEPTH, the byte is dropped and overflow is set to 1.
  - prog_en falling discards a partial byte and returns to IDLE.
- IDLE -> SCAN_START when run=1, prog_en=0 and prog_len!=0. If run=1 with prog_len=0, stay in IDLE.
- SCAN_START (1 cycle): ui_in_prev<=ui_cur, ui_cur<=ui_in, pc<=0.
- ISSUE (1 cycle):
  - instr<=mem[pc] and instr_ready=1 for exactly one cycle.
  - Go to SCAN_END if mem[pc]==END_OP (8'hFF) or pc==prog_len-1. END_OP itself is issued.
  - Otherwise pc++ and go to GAP, or straight back to ISSUE when GAP_CYCLES=0.
- GAP: instr_ready=0 for GAP_CYCLES cycles, then ISSUE. instr holds its last value.
- SCAN_END (1 cycle): scan_done=1.
  - If run=1, go to SCAN_START (back-to-back scans).
  - If run=0, go to IDLE. Deasserting run mid-scan still completes the current scan.
- Latency: run sampled high at edge k -> SCAN_START after k -> first instr_ready high after edge k+1. Instruction spacing is GAP_CYCLES+1 cycles.
- Scan length: N instructions gives N + N-1 gaps + 2 overhead cycles, i.e. 2N+1 cycles at GAP_CYCLES=1.
- prog_strobe edges outside LOAD are ignored. The strobe edge detector register runs in all states, so there is no spurious edge on entering LOAD.
- Reset asserted mid-operation: immediate return to reset values. prog_len=0 after reset, so the RAM is treated as empty.

Decomposition:
- Shared package vslc_pkg:
  - fetcher state enum (3-bit encoding)
  - END_OP=8'hFF
  - executor opcode class constants (REG_A=2'b00, REG_B=2'b01, LOGIC=2'b10, OTHER=2'b11), so that executor and fetcher agree.
- One sub-module, tt_um_jimktrains_vslc_prog_shift: strobe edge detect, 3-bit bit counter and 8-bit shift register, emitting byte_valid/byte_data. Clear input is driven on LOAD entry.
- RAM is inferred inline in the fetcher.

Test Plan:
- Load 0x01,0x82,0xFF via serial, then run=1 for one scan -> prog_len=3, overflow=0. instr_ready pulses with instr=0x01,0x82,0xFF on cycles 2,4,6 after run. scan_done on cycle 7. IDLE after run drops.
- Load 5 bytes with the 3rd =0xFF -> only 3 strobes per scan. pc never reaches 3, and prog_len=5.
- DEPTH=16, load 18 bytes -> prog_len=16, overflow=1. mem[15] holds byte 16. Re-entering LOAD clears overflow.
- Run continuously with ui_in=0x00, then 0x5A, across scans -> ui_in_prev in scan n equals the ui_in sampled at SCAN_START of scan n-1 (0x00, then 0x5A).
- prog_en asserted during GAP of a scan -> instr_ready stays 0, no scan_done, state LOAD on the next edge. A 4-bit partial byte followed by prog_en low leaves prog_len unchanged.
- rst pulsed asynchronously mid-ISSUE -> all outputs 0 without a clock edge. run=1 after reset stays IDLE because prog_len=0.
